// File: rtl/mux4_1_rr_arbiter.sv
// mux4_1_rr_arbiter: 4:1 valid/ready mux with one registered output stage and source tag on {S2,S1}.
// RR_ARB_EN selects round-robin arbitration; without it channel 1 > 2 > 3 > 4 fixed priority.
module mux4_1_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] A3,
    input  logic [WIDTH-1:0] A4,
    input  logic             V1,
    input  logic             V2,
    input  logic             V3,
    input  logic             V4,
    output logic             R1,
    output logic             R2,
    output logic             R3,
    output logic             R4,
    output logic [WIDTH-1:0] Y,
    output logic             YV,
    input  logic             YR,
    output logic             S2,
    output logic             S1
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t           r_state, w_next;
    logic [3:0]       w_v, w_rdy, w_win;
    logic [1:0]       w_sel, w_ptr, r_s;
    logic             w_free, w_xfer;
    logic [WIDTH-1:0] w_a [4];
    logic [WIDTH-1:0] r_y;

    assign w_v    = {V4, V3, V2, V1};
    assign w_a[0] = A1;
    assign w_a[1] = A2;
    assign w_a[2] = A3;
    assign w_a[3] = A4;

    // Ready of channel i only looks at channels ahead of it in search order, never at its own valid.
    function automatic logic [3:0] grant(input logic [3:0] v, input logic [1:0] ptr);
        logic [1:0] di, dj;
        grant = '0;
        for (int i = 0; i < 4; i++) begin
            di = 2'(i) - ptr - 2'd1;
            grant[i] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                dj = 2'(j) - ptr - 2'd1;
                if (dj < di && v[j]) grant[i] = 1'b0;
            end
        end
    endfunction

`ifdef RR_ARB_EN
    logic [1:0] r_ptr;
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= 2'd3;
        else if (w_xfer) r_ptr <= w_sel;
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd3;
`endif

    assign w_free = (r_state == IDLE) || YR;
    assign w_rdy  = (w_free && !rst) ? grant(w_v, w_ptr) : 4'b0000;
    assign w_win  = w_rdy & w_v;
    assign w_xfer = |w_win;
    assign w_sel  = {w_win[3] | w_win[2], w_win[3] | w_win[1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = w_xfer ? HOLD : (r_state == HOLD && YR) ? IDLE : r_state;
    end

    always_comb begin
        YV               = (r_state == HOLD);
        {R4, R3, R2, R1} = w_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
            r_s <= 2'b00;
        end else if (w_xfer) begin
            r_y <= w_a[w_sel];
            r_s <= w_sel;
        end
    end

    assign Y        = r_y;
    assign {S2, S1} = r_s;
endmodule

// File: tb/tb_mux4_1_rr_arbiter.sv
// tb_mux4_1_rr_arbiter: table-driven bench with a scoreboard queue for mux4_1_rr_arbiter.
// Rows carry the expected winner for both RR_ARB_EN and fixed-priority builds.
module tb_mux4_1_rr_arbiter;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             YR = 1'b0;
    logic [3:0]       V = '0;
    logic [3:0][7:0]  A = '0;
    logic [3:0]       R;
    logic [7:0]       Y;
    logic             YV, S2, S1;

    typedef struct {
        logic            rst;
        logic            yr;
        logic [3:0]      v;
        logic [3:0][7:0] a;
        int              er;
        int              ef;
    } row_t;

    row_t       tbl[$];
    logic [9:0] sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] m_y;
    logic [1:0] m_s;
    logic       m_yv;

    always #5 clk = ~clk;

    mux4_1_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .A1(A[0]), .A2(A[1]), .A3(A[2]), .A4(A[3]),
        .V1(V[0]), .V2(V[1]), .V3(V[2]), .V4(V[3]),
        .R1(R[0]), .R2(R[1]), .R3(R[2]), .R4(R[3]),
        .Y(Y), .YV(YV), .YR(YR), .S2(S2), .S1(S1)
    );

    function automatic row_t mk(input logic r, input logic yr, input logic [3:0] v,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic [7:0] a3,
                                input int er, input int ef);
        mk.rst = r; mk.yr = yr; mk.v = v;
        mk.a[0] = a0; mk.a[1] = a1; mk.a[2] = a2; mk.a[3] = a3;
        mk.er = er; mk.ef = ef;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one row at the falling edge, check readies, then check the registered output after the edge.
    task automatic step(input row_t r);
        int         e;
        logic [9:0] w;
        rst = r.rst; YR = r.yr; V = r.v; A = r.a;
`ifdef RR_ARB_EN
        e = r.er;
`else
        e = r.ef;
`endif
        #1;
        if (r.rst) chk("ready_in_reset", {28'd0, R}, 32'd0);
        else chk("grant", {28'd0, R & V}, (e == 4) ? 32'd0 : (32'd1 << e));
        if (!r.rst && e != 4) sb.push_back({A[e], 2'(e)});
        @(posedge clk);
        #1;
        if (r.rst) begin
            m_yv = 1'b0; m_y = '0; m_s = '0;
            sb.delete();
        end else if (e != 4) begin
            w = sb.pop_front();
            {m_y, m_s} = w;
            m_yv = 1'b1;
        end else if (m_yv && r.yr) m_yv = 1'b0;
        chk("out_yv_y_s", {21'd0, YV, Y, S2, S1}, {21'd0, m_yv, m_y, m_s});
        @(negedge clk);
    endtask

    initial begin
        tbl.push_back(mk(1, 1, 4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 4, 4));
        tbl.push_back(mk(1, 1, 4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 4, 4));
        tbl.push_back(mk(0, 1, 4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, 8'h10, 8'h20, 8'hA5, 8'h40, 2, 2));
        tbl.push_back(mk(0, 1, 4'b0100, 8'h10, 8'h20, 8'h5A, 8'h40, 2, 2));
        tbl.push_back(mk(0, 1, 4'b0000, 8'h10, 8'h20, 8'h30, 8'h40, 4, 4));
        tbl.push_back(mk(0, 1, 4'b0010, 8'h10, 8'h3C, 8'h30, 8'h40, 1, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 4'b0001, 8'h10, 8'h20, 8'h30, 8'h40, 4, 4));
        tbl.push_back(mk(0, 1, 4'b0001, 8'h10, 8'h20, 8'h30, 8'h40, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, (i + 1) % 4, 0));
        tbl.push_back(mk(0, 1, 4'b1110, 8'h10, 8'h20, 8'h30, 8'h40, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1110, 8'h10, 8'h20, 8'h30, 8'h40, 2, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 8'h10, 8'h20, 8'h30, 8'h40, 4, 4));

        @(negedge clk);
        foreach (tbl[k]) step(tbl[k]);

        // Reset while a word is held under backpressure: the held word must vanish.
        step(mk(0, 1, 4'b0001, 8'hEE, 8'h20, 8'h30, 8'h40, 0, 0));
        step(mk(0, 0, 4'b0000, 8'hEE, 8'h20, 8'h30, 8'h40, 4, 4));
        chk("held_before_reset", {23'd0, YV, Y}, {23'd0, 1'b1, 8'hEE});
        step(mk(1, 0, 4'b0000, 8'hEE, 8'h20, 8'h30, 8'h40, 4, 4));
        chk("yv_after_reset", {31'd0, YV}, 32'd0);
        step(mk(0, 1, 4'b1000, 8'h10, 8'h20, 8'h30, 8'h77, 3, 3));
        chk("after_reset_word", {22'd0, Y, S2, S1}, {22'd0, 8'h77, 2'b11});
        step(mk(0, 1, 4'b0000, 8'h10, 8'h20, 8'h30, 8'h77, 4, 4));
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
